// File: rtl/stereo_capture_arbiter_if.sv
// stereo_capture_arbiter_if: frame-buffer write port with valid/ready handshake.
interface stereo_capture_arbiter_if #(
   parameter int AW = 18
);
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          wr_ready;
   modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/stereo_capture_arbiter.sv
// stereo_capture_arbiter: captures one frame per camera into per-camera FIFOs and
// round-robins them onto a single frame-buffer write port, right frame after left.
module stereo_capture_arbiter #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int FIFO_DEPTH = 4,
   parameter int AW         = 18
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] l_value,
   input  logic [9:0] l_x,
   input  logic [9:0] l_y,
   input  logic       l_is_val,
   input  logic [7:0] r_value,
   input  logic [9:0] r_x,
   input  logic [9:0] r_y,
   input  logic       r_is_val,
   stereo_capture_arbiter_if.master wr,
   output logic       busy,
   output logic       done,
   output logic [1:0] overflow
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 28;
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
   state_t        st_q [2];
   state_t        st_d [2];
   logic [EW-1:0] mem_q [2][FIFO_DEPTH];
   logic [PW-1:0] wp_q [2];
   logic [PW-1:0] wp_d [2];
   logic [PW-1:0] rp_q [2];
   logic [PW-1:0] rp_d [2];
   logic [PW:0]   cnt_q [2];
   logic [PW:0]   cnt_d [2];
   logic [EW-1:0] pix [2];
   logic          pv [2];
   logic          push [2];
   logic          wr_en [2];
   logic          pop [2];
   logic          ne [2];
   logic          full [2];
   logic          last [2];
   logic [1:0]    ovf_set;
   logic [EW-1:0] sel;
   logic          rr_q, rr_d, grant, load, start_ok, fin;
   logic          busy_q, busy_d, done_q, done_d;
   logic [1:0]    overflow_q, overflow_d;
   logic          wr_valid_q, wr_valid_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   always_comb begin
      pix[0] = {l_value, l_x, l_y};
      pix[1] = {r_value, r_x, r_y};
      pv[0] = l_is_val;
      pv[1] = r_is_val;
      start_ok = start && st_q[0] == IDLE && st_q[1] == IDLE && !busy_q;
      for (int c = 0; c < 2; c++) begin
         ne[c] = cnt_q[c] != '0;
         full[c] = cnt_q[c] == (PW+1)'(FIFO_DEPTH);
      end
      // rr_q names the camera preferred when both FIFOs hold data
      grant = (ne[0] && ne[1]) ? rr_q : ne[1];
      load = (!wr_valid_q || wr.wr_ready) && (ne[0] || ne[1]);
      rr_d = load ? ~grant : rr_q;
      fin = st_q[0] == DONE && st_q[1] == DONE && !ne[0] && !ne[1] && (!wr_valid_q || wr.wr_ready);
      done_d = fin && !done_q;
      busy_d = start_ok || (busy_q && !done_d);
      for (int c = 0; c < 2; c++) begin
         pop[c] = load && grant == c[0];
         last[c] = pix[c][19:10] == 10'(WIDTH-1) && pix[c][9:0] == 10'(HEIGHT-1);
         push[c] = pv[c] && ((st_q[c] == ARMED && pix[c][19:0] == '0) || st_q[c] == CAPTURE);
         wr_en[c] = push[c] && (!full[c] || pop[c]);
         ovf_set[c] = push[c] && full[c] && !pop[c];
         wp_d[c] = wp_q[c] + PW'(wr_en[c]);
         rp_d[c] = rp_q[c] + PW'(pop[c]);
         cnt_d[c] = cnt_q[c] + (PW+1)'(wr_en[c]) - (PW+1)'(pop[c]);
         st_d[c] = st_q[c];
         // a dropped final pixel still ends the frame, so overflow cannot stall completion
         case (st_q[c])
            IDLE:    st_d[c] = start_ok ? ARMED : IDLE;
            ARMED:   st_d[c] = push[c] ? (last[c] ? DONE : CAPTURE) : ARMED;
            CAPTURE: st_d[c] = (push[c] && last[c]) ? DONE : CAPTURE;
            DONE:    st_d[c] = done_q ? IDLE : DONE;
            default: st_d[c] = IDLE;
         endcase
      end
      overflow_d = start_ok ? 2'b00 : overflow_q | ovf_set;
      sel = grant ? mem_q[1][rp_q[1]] : mem_q[0][rp_q[0]];
      wr_valid_d = (!wr_valid_q || wr.wr_ready) ? load : wr_valid_q;
      wr_addr_d = load ? AW'(grant ? WIDTH*HEIGHT : 0) + AW'(sel[9:0]) * AW'(WIDTH) + AW'(sel[19:10]) : wr_addr_q;
      wr_data_d = load ? sel[27:20] : wr_data_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < 2; c++) begin
            st_q[c] <= IDLE;
            wp_q[c] <= '0;
            rp_q[c] <= '0;
            cnt_q[c] <= '0;
         end
         rr_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         overflow_q <= 2'b00;
         wr_valid_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            st_q[c] <= st_d[c];
            wp_q[c] <= wp_d[c];
            rp_q[c] <= rp_d[c];
            cnt_q[c] <= cnt_d[c];
         end
         rr_q <= rr_d;
         busy_q <= busy_d;
         done_q <= done_d;
         overflow_q <= overflow_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end
   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++)
         if (wr_en[c]) mem_q[c][wp_q[c]] <= pix[c];
   end
   assign wr.wr_valid = wr_valid_q;
   assign wr.wr_addr = wr_addr_q;
   assign wr.wr_data = wr_data_q;
   assign busy = busy_q;
   assign done = done_q;
   assign overflow = overflow_q;
endmodule
